// File: rtl/red_pitaya_mux_scheduler.sv
// FADS analog input mux sequencer: round-robin over enabled channels with
// one-shot priority slots, each slot = 1 select + S settle + D dwell cycles.
module red_pitaya_mux_scheduler #(
    parameter int CHNL = 6,
    parameter int AW   = 3,
    parameter int TW   = 16
) (
    input  logic            adc_clk_i,
    input  logic            adc_rstn_i,
    input  logic            enable_i,
    input  logic [CHNL-1:0] active_channels_i,
    input  logic [TW-1:0]   settle_cycles_i,
    input  logic [TW-1:0]   dwell_cycles_i,
    input  logic            req_valid_i,
    input  logic [AW-1:0]   req_chan_i,
    output logic            req_ready_o,
    output logic [AW-1:0]   mux_addr_o,
    output logic            settling_o,
    output logic            sample_valid_o,
    output logic [AW-1:0]   sample_chan_o,
    output logic            frame_done_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_DWELL
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_rr_ptr;
    logic          r_pending;
    logic [AW-1:0] r_pend_chan;
    logic [AW-1:0] r_mux_addr;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] r_dwell;

    logic          w_xfer;
    logic          w_req_in_range;
    logic          w_found;
    logic [AW-1:0] w_found_idx;
    logic          w_wrap;
    logic          w_sel_go;
    logic          w_cnt_zero;
    logic [TW-1:0] w_dwell_eff;

    assign w_xfer         = req_valid_i && !r_pending;
    assign w_req_in_range = (int'(req_chan_i) < CHNL);
    assign w_dwell_eff    = (dwell_cycles_i == '0) ? TW'(1) : dwell_cycles_i;
    assign w_cnt_zero     = (r_cnt == '0);
    assign w_sel_go       = r_pending || w_found;

    // The active channel closest after r_rr_ptr (cyclic distance) wins.
    always_comb begin
        int v_best;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        w_found     = 1'b0;
        w_found_idx = '0;
        v_best      = CHNL;
        for (int c = 0; c < CHNL; c++) begin
            if (active_channels_i[c] &&
                (((c + CHNL - 1 - int'(r_rr_ptr)) % CHNL) < v_best)) begin
                v_best      = (c + CHNL - 1 - int'(r_rr_ptr)) % CHNL;
                w_found     = 1'b1;
                w_found_idx = AW'(c);
            end
        end
    end

    assign w_wrap = w_found && (w_found_idx <= r_rr_ptr);

    always_ff @(posedge adc_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (adc_rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable_i && ((active_channels_i != '0) || r_pending)) begin
                    w_state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!w_sel_go) begin
                    w_state_nxt = ST_IDLE;
                end else if (settle_cycles_i != '0) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (w_cnt_zero) begin
                    w_state_nxt = enable_i ? ST_SELECT : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rstn_i) begin
            r_rr_ptr    <= AW'(CHNL - 1);
            r_pending   <= 1'b0;
            r_pend_chan <= '0;
            r_mux_addr  <= '0;
            r_cnt       <= '0;
            r_dwell     <= '0;
        end else begin
            // A pending request is only accepted while nothing is pending, so the
            // two branches never compete for the same edge.
            if ((r_state == ST_SELECT) && r_pending) begin
                r_pending <= 1'b0;
            end else if (w_xfer && w_req_in_range) begin
                r_pending   <= 1'b1;
                r_pend_chan <= req_chan_i;
            end

            case (r_state)
                ST_SELECT: begin
                    if (w_sel_go) begin
                        if (r_pending) begin
                            r_mux_addr <= r_pend_chan;
                        end else begin
                            r_mux_addr <= w_found_idx;
                            r_rr_ptr   <= w_found_idx;
                        end
                        r_dwell <= w_dwell_eff;
                        // Counter holds remaining cycles minus one of the window being entered.
                        r_cnt   <= (settle_cycles_i != '0) ? (settle_cycles_i - TW'(1))
                                                           : (w_dwell_eff - TW'(1));
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= w_cnt_zero ? (r_dwell - TW'(1)) : (r_cnt - TW'(1));
                end
                ST_DWELL: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o    = !r_pending;
    assign mux_addr_o     = r_mux_addr;
    assign settling_o     = (r_state == ST_SETTLE);
    assign sample_valid_o = (r_state == ST_DWELL);
    assign sample_chan_o  = (r_state == ST_DWELL) ? r_mux_addr : '0;
    assign frame_done_o   = (r_state == ST_SELECT) && !r_pending && w_wrap;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_red_pitaya_mux_scheduler.sv
// Self-checking bench: a slot-level model (rotation pointer, pending request)
// predicts each slot's channel, frame_done and window lengths.
module tb_red_pitaya_mux_scheduler;

    localparam int CHNL = 6;
    localparam int AW   = 3;
    localparam int TW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [CHNL-1:0] mask = '0;
    logic [TW-1:0]   s_in = '0;
    logic [TW-1:0]   d_in = '0;
    logic            req_valid = 1'b0;
    logic [AW-1:0]   req_chan = '0;

    logic            req_ready_o;
    logic [AW-1:0]   mux_addr_o;
    logic            settling_o;
    logic            sample_valid_o;
    logic [AW-1:0]   sample_chan_o;
    logic            frame_done_o;
    logic            busy_o;

    int checks   = 0;
    int failures = 0;

    // Slot-level reference state
    int m_rr;
    bit m_pending;
    int m_pend_chan;
    int cur_s;
    int cur_deff;

    red_pitaya_mux_scheduler #(.CHNL(CHNL), .AW(AW), .TW(TW)) dut (
        .adc_clk_i         (clk),
        .adc_rstn_i        (rst),
        .enable_i          (enable),
        .active_channels_i (mask),
        .settle_cycles_i   (s_in),
        .dwell_cycles_i    (d_in),
        .req_valid_i       (req_valid),
        .req_chan_i        (req_chan),
        .req_ready_o       (req_ready_o),
        .mux_addr_o        (mux_addr_o),
        .settling_o        (settling_o),
        .sample_valid_o    (sample_valid_o),
        .sample_chan_o     (sample_chan_o),
        .frame_done_o      (frame_done_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_rr        = CHNL - 1;
        m_pending   = 1'b0;
        m_pend_chan = 0;
    endtask

    // Next slot: pending request first, otherwise next active channel after m_rr.
    task automatic next_slot(output int chan, output bit fd, output bit ok);
        chan = 0;
        fd   = 1'b0;
        ok   = 1'b0;
        if (m_pending) begin
            chan      = m_pend_chan;
            m_pending = 1'b0;
            ok        = 1'b1;
            return;
        end
        for (int d = 1; d <= CHNL; d++) begin
            int c;
            c = (m_rr + d) % CHNL;
            if (mask[c]) begin
                chan = c;
                fd   = (c <= m_rr);
                m_rr = c;
                ok   = 1'b1;
                return;
            end
        end
    endtask

    task automatic set_cfg(input logic [CHNL-1:0] m, input int s, input int d);
        mask     = m;
        s_in     = TW'(s);
        d_in     = TW'(d);
        cur_s    = s;
        cur_deff = (d == 0) ? 1 : d;
    endtask

    // Waits for the next SELECT cycle, then checks one whole slot. Optional
    // request stimulus during dwell and optional enable drop during settle.
    task automatic check_slot(input int ec, input bit efd, input int s, input int d,
                              input int req_at, input int req_n, input int rq_a,
                              input int rq_b, input bit drop_en,
                              output int gap, output int obs);
        logic [AW-1:0] ea;
        bit found;
        int err;
        int rc;
        ea    = AW'(ec);
        gap   = 0;
        found = 1'b0;
        err   = 0;
        obs   = -1;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            gap++;
            if (busy_o === 1'b1 && settling_o === 1'b0 && sample_valid_o === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL slot_start: no select cycle within 64 cycles, expected chan %0d", ec);
            return;
        end
        checks++;
        if (frame_done_o !== efd) begin
            failures++;
            $display("FAIL frame_done: chan %0d got %b want %b", ec, frame_done_o, efd);
        end
        for (int i = 0; i < s; i++) begin
            @(negedge clk);
            if (settling_o !== 1'b1 || sample_valid_o !== 1'b0 || mux_addr_o !== ea ||
                frame_done_o !== 1'b0 || busy_o !== 1'b1) err++;
            if (req_ready_o !== !m_pending) err++;
            if (drop_en && i == 0) enable = 1'b0;
        end
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (sample_valid_o !== 1'b1 || settling_o !== 1'b0 || mux_addr_o !== ea ||
                sample_chan_o !== ea || frame_done_o !== 1'b0 || busy_o !== 1'b1) err++;
            if (req_ready_o !== !m_pending) err++;
            if (i == 0) begin
                obs = int'(sample_chan_o);
                checks++;
                if (sample_chan_o !== ea) begin
                    failures++;
                    $display("FAIL sample_chan: got %0d want %0d", sample_chan_o, ea);
                end
            end
            if (req_at >= 0 && i >= req_at && i < req_at + req_n) begin
                rc        = (i == req_at) ? rq_a : rq_b;
                req_valid = 1'b1;
                req_chan  = AW'(rc);
                if (!m_pending && rc < CHNL) begin
                    m_pending   = 1'b1;
                    m_pend_chan = rc;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL slot_shape: chan %0d S=%0d D=%0d bad cycles %0d want 0", ec, s, d, err);
        end
    endtask

    task automatic run_slots(input int n, input bit chk_gap);
        int ch, gap, obs;
        bit fd, ok;
        for (int k = 0; k < n; k++) begin
            next_slot(ch, fd, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL model_slot: reference has no slot to schedule");
                return;
            end
            check_slot(ch, fd, cur_s, cur_deff, -1, 0, 0, 0, 1'b0, gap, obs);
            if (chk_gap && k > 0) begin
                checks++;
                if (gap != 1) begin
                    failures++;
                    $display("FAIL slot_period: gap %0d cycles want 1 (chan %0d)", gap, ch);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mux_addr_o, settling_o, sample_valid_o, sample_chan_o, frame_done_o, busy_o, req_ready_o}
            !== {3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: addr=%0d set=%b sv=%b sc=%0d fd=%b busy=%b rdy=%b",
                     mux_addr_o, settling_o, sample_valid_o, sample_chan_o, frame_done_o,
                     busy_o, req_ready_o);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_rotation();
        int ch, gap, obs;
        bit fd, ok;
        int want [4] = '{0, 2, 5, 0};
        set_cfg(6'b100101, 2, 3);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_slot(ch, fd, ok);
            check_slot(ch, fd, cur_s, cur_deff, -1, 0, 0, 0, 1'b0, gap, obs);
            if (k < 4) begin
                checks++;
                if (obs != want[k]) begin
                    failures++;
                    $display("FAIL rotation_seq[%0d]: got %0d want %0d", k, obs, want[k]);
                end
            end
            if (k > 0) begin
                checks++;
                if (gap != 1) begin
                    failures++;
                    $display("FAIL rotation_period: gap %0d want 1", gap);
                end
            end
        end
    endtask

    task automatic test_single_channel();
        set_cfg(6'b001000, 0, 0);
        run_slots(6, 1'b1);
    endtask

    task automatic test_priority();
        int ch, gap, obs, after;
        bit fd, ok, sent;
        int got [3];
        int want [3] = '{4, 1, 2};
        set_cfg(6'b000111, 1, 3);
        sent  = 1'b0;
        after = 0;
        for (int k = 0; k < 10 && after < 3; k++) begin
            next_slot(ch, fd, ok);
            if (!sent && ch == 0) begin
                check_slot(ch, fd, cur_s, cur_deff, 0, 1, 4, 4, 1'b0, gap, obs);
                sent = 1'b1;
            end else begin
                check_slot(ch, fd, cur_s, cur_deff, -1, 0, 0, 0, 1'b0, gap, obs);
                if (sent) begin
                    got[after] = obs;
                    after++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] != want[i]) begin
                failures++;
                $display("FAIL priority_seq[%0d]: got %0d want %0d", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_bad_request();
        int ch, gap, obs;
        bit fd, ok;
        // Out-of-range channel is swallowed; the rotation continues normally.
        next_slot(ch, fd, ok);
        check_slot(ch, fd, cur_s, cur_deff, 0, 1, 7, 7, 1'b0, gap, obs);
        run_slots(2, 1'b1);
        // Second request while one is pending is refused.
        next_slot(ch, fd, ok);
        check_slot(ch, fd, cur_s, cur_deff, 0, 2, 2, 5, 1'b0, gap, obs);
        run_slots(4, 1'b1);
    endtask

    task automatic test_random();
        int ch, gap, obs, ra, rn, rq;
        bit fd, ok;
        for (int r = 0; r < 6; r++) begin
            set_cfg(CHNL'($urandom_range(1, (1 << CHNL) - 1)), $urandom_range(0, 3),
                    $urandom_range(0, 3));
            for (int k = 0; k < 6; k++) begin
                next_slot(ch, fd, ok);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL random_model: no slot with mask %b", mask);
                    return;
                end
                ra = -1;
                rn = 0;
                rq = 0;
                if (cur_deff >= 2 && $urandom_range(0, 2) == 0) begin
                    ra = 0;
                    rn = 1;
                    rq = $urandom_range(0, 7);
                end
                check_slot(ch, fd, cur_s, cur_deff, ra, rn, rq, rq, 1'b0, gap, obs);
                if (k > 0) begin
                    checks++;
                    if (gap != 1) begin
                        failures++;
                        $display("FAIL random_period: gap %0d want 1", gap);
                    end
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        int ch, gap, obs, err;
        bit fd, ok;
        logic [AW-1:0] ea;
        set_cfg(6'b000111, 2, 3);
        next_slot(ch, fd, ok);
        check_slot(ch, fd, cur_s, cur_deff, -1, 0, 0, 0, 1'b1, gap, obs);
        ea  = AW'(ch);
        err = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || mux_addr_o !== ea || settling_o !== 1'b0 ||
                sample_valid_o !== 1'b0) err++;
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL enable_drop_idle: bad cycles %0d want 0", err);
        end
        enable = 1'b1;
        run_slots(2, 1'b1);
    endtask

    task automatic test_reset_mid_dwell();
        bit sv;
        sv = 1'b0;
        for (int k = 0; k < 40 && !sv; k++) begin
            @(negedge clk);
            if (sample_valid_o === 1'b1) sv = 1'b1;
        end
        checks++;
        if (!sv) begin
            failures++;
            $display("FAIL reset_mid_wait: no dwell cycle within 40 cycles");
            return;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mux_addr_o, settling_o, sample_valid_o, sample_chan_o, frame_done_o, busy_o, req_ready_o}
            !== {3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_outputs: addr=%0d set=%b sv=%b busy=%b rdy=%b",
                     mux_addr_o, settling_o, sample_valid_o, busy_o, req_ready_o);
        end
        rst = 1'b0;
        model_reset();
        run_slots(3, 1'b1);
    endtask

    task automatic test_idle_mask0();
        int ch, gap, obs, err;
        bit fd, ok;
        set_cfg('0, 1, 2);
        @(negedge clk);
        err = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_o !== 1'b0) err++;
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL mask0_idle: busy cycles %0d want 0", err);
        end
        req_valid = 1'b1;
        req_chan  = 3'd1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL idle_req_ready: got %b want 1", req_ready_o);
        end
        m_pending   = 1'b1;
        m_pend_chan = 1;
        @(negedge clk);
        req_valid = 1'b0;
        next_slot(ch, fd, ok);
        check_slot(ch, fd, cur_s, cur_deff, -1, 0, 0, 0, 1'b0, gap, obs);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_final_select: busy=%b fd=%b want busy=1 fd=0", busy_o, frame_done_o);
        end
        err = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || mux_addr_o !== 3'd1) err++;
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL idle_after_req: bad cycles %0d want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_channel();
        test_priority();
        test_bad_request();
        test_random();
        test_enable_drop();
        test_reset_mid_dwell();
        test_idle_mask0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/red_pitaya_mux_scheduler.md
Name: red_pitaya_mux_scheduler

Overview:
Sequencer for the FADS analog input multiplexer. Steps the mux round-robin through the enabled detector channels. Each slot has a programmable settle (blanking) window followed by a dwell (acquisition) window. Marks valid ADC samples with their channel tag. Accepts one-shot priority requests that pre-empt the rotation for a single slot. Sits between the FADS configuration registers and the mux address pins, and feeds the per-channel detection logic.

Parameters:
CHNL, 6, number of mux channels (1..8)
AW, 3, mux address width
TW, 16, width of settle/dwell counters

Ports:
adc_clk_i  in  1  ADC clock; all logic on rising edge
adc_rstn_i  in  1  synchronous reset, active-high
enable_i  in  1  run scheduler
active_channels_i  in  CHNL  round-robin enable mask
settle_cycles_i  in  TW  blanking cycles after each address change
dwell_cycles_i  in  TW  acquisition cycles per slot (0 treated as 1)
req_valid_i  in  1  priority request valid
req_chan_i  in  AW  requested channel
req_ready_o  out  1  request can be accepted
mux_addr_o  out  AW  mux address pins
settling_o  out  1  high during the settle window
sample_valid_o  out  1  high during the dwell window
sample_chan_o  out  AW  channel tag for the current sample
frame_done_o  out  1  one-cycle pulse when the round-robin wraps
busy_o  out  1  state != IDLE

Behaviour:
- Reset (adc_rstn_i=1 at an edge) applies immediately, from any state:
  - all outputs 0 except req_ready_o=1;
  - state=IDLE; rr_ptr=CHNL-1; pending=0; counters=0.
- Request handshake:
  - A transfer occurs when req_valid_i && req_ready_o.
  - req_ready_o = !pending.
  - On transfer: if req_chan_i < CHNL, then pending<=1 and pend_chan<=req_chan_i. If req_chan_i >= CHNL, the request is accepted and discarded (pending stays 0).
  - Requested channel need not be set in active_channels_i.
  - Accepted in any state, including IDLE.
- IDLE:
  - Outputs idle, mux_addr_o holds its last value.
  - Go to SELECT when enable_i && (active_channels_i != 0 || pending).
- SELECT (exactly 1 cycle):
  - If pending: mux_addr_o<=pend_chan, pending<=0. rr_ptr is unchanged (priority slots do not advance the rotation).
  - Else: search indices rr_ptr+1, rr_ptr+2, ... modulo CHNL, up to CHNL steps. The first index with its active bit set becomes mux_addr_o and rr_ptr.
    - If the found index <= old rr_ptr, pulse frame_done_o in this same cycle.
    - With a single active channel, that channel is reselected and frame_done_o pulses every slot.
  - If neither a pending request nor any active bit exists: go to IDLE, mux_addr_o unchanged.
  - Latch S=settle_cycles_i and D=max(dwell_cycles_i,1).
  - Next state: SETTLE if S>0, else DWELL.
- SETTLE:
  - settling_o=1 for exactly S cycles, then DWELL.
- DWELL:
  - sample_valid_o=1 and sample_chan_o=mux_addr_o for exactly D cycles.
  - After the last dwell cycle: go to SELECT if enable_i, else IDLE.
- Slot period = 1 + S + D cycles. mux_addr_o changes only on the cycle entering SETTLE/DWELL from SELECT.
- Mid-slot changes:
  - enable_i deassert mid-slot: the current slot completes, then IDLE.
  - active_channels_i changes take effect at the next SELECT.
- Simultaneous request accept and SELECT in the same cycle: SELECT uses the old pending state. The new request is served at the following SELECT.
- Counters are TW bits and do not wrap. A value of 2^TW-1 gives that many cycles.

Test Plan:
- Reset, then CHNL=6, mask=6'b100101, S=2, D=3, enable=1 -> mux_addr sequence 0,2,5,0,...; slot period 6 cycles; settling high 2 cycles, sample_valid high 3 cycles per slot; frame_done pulses when 0 is selected after 5.
- mask=6'b001000, S=0, D=0 -> mux_addr stays 3; sample_valid high 1 cycle of every 2; frame_done pulses every SELECT.
- Request chan 4 during the dwell of chan 0 (mask=6'b000111) -> sequence 0,4,1,2; req_ready_o low from the accept until the SELECT that serves it; the rotation resumes at 1.
- Request with req_chan_i=7 -> accepted (ready stays 1), no change to the sequence. A second request while one is pending -> req_ready_o=0, no transfer.
- Deassert enable mid-settle -> the slot completes its S+D cycles, then busy_o=0 and mux_addr holds. Assert reset mid-dwell -> next cycle all outputs 0, rotation restarts at the lowest active channel.
- mask=0 with enable=1 -> stays IDLE. Then a request for chan 1 -> one slot on chan 1, then IDLE.
